// File: rtl/instr_queue_reg.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, with bypass into the IR
// when the queue is empty and output-enable gating of the opcode/address fields.
module instr_queue_reg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = DATA_W - OP_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              Ii,
    input  logic              Inext,
    input  logic              flush,
    input  logic              Io,
    output logic [OP_W-1:0]   opt,
    output logic [ADDR_W-1:0] addt,
    output logic [OP_W-1:0]   op_code_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              ir_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [OP_W-1:0]   opt_q, opt_d;
    logic [ADDR_W-1:0] addt_q, addt_d;
    logic              ir_valid_q, ir_valid_d;
    logic              overflow_q, overflow_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    logic              is_full, is_empty;
    logic              push_ok, pop, bypass;
    logic [DATA_W-1:0] head;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    // Next-state: flush dominates; otherwise pop/bypass into IR and push into FIFO
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        opt_d      = opt_q;
        addt_d     = addt_q;
        ir_valid_d = ir_valid_q;
        overflow_d = overflow_q;
        push_ok    = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            bypass  = Inext && is_empty && Ii;
            pop     = Inext && !is_empty;
            push_ok = Ii && !is_full && !bypass;

            // A full queue never forwards the incoming word, even when popping
            if (Ii && is_full) begin
                overflow_d = 1'b1;
            end

            if (pop) begin
                opt_d      = head[DATA_W-1:ADDR_W];
                addt_d     = head[ADDR_W-1:0];
                ir_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
            end else if (bypass) begin
                opt_d      = data_in[DATA_W-1:ADDR_W];
                addt_d     = data_in[ADDR_W-1:0];
                ir_valid_d = 1'b1;
            end else if (Inext) begin
                ir_valid_d = 1'b0;
            end

            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            opt_q      <= '0;
            addt_q     <= '0;
            ir_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            opt_q      <= opt_d;
            addt_q     <= addt_d;
            ir_valid_q <= ir_valid_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign opt       = opt_q;
    assign addt      = addt_q;
    assign ir_valid  = ir_valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign op_code_o = (Io && ir_valid_q) ? opt_q  : '0;
    assign address_o = (Io && ir_valid_q) ? addt_q : '0;

endmodule

// File: tb/tb_instr_queue_reg.sv
// Randomised and directed bench for instr_queue_reg: default 8/4/4 instance and a
// 12/4/8 instance share stimulus and are each checked against a list-based model.
module tb_instr_queue_reg;

    logic        clk = 1'b0;
    logic        rst, ii, inext, flush, io;
    logic [11:0] din;
    logic [7:0]  din_a;
    logic        chk_en;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign din_a = din[7:0];

    logic [3:0] opt_a, addt_a, opc_a, adr_a;
    logic [2:0] count_a;
    logic       irv_a, full_a, empty_a, ovf_a;
    logic [3:0] opt_b, opc_b;
    logic [7:0] addt_b, adr_b;
    logic [3:0] count_b;
    logic       irv_b, full_b, empty_b, ovf_b;

    instr_queue_reg u_a (
        .clk(clk), .rst(rst), .data_in(din_a), .Ii(ii), .Inext(inext), .flush(flush), .Io(io),
        .opt(opt_a), .addt(addt_a), .op_code_o(opc_a), .address_o(adr_a), .ir_valid(irv_a),
        .full(full_a), .empty(empty_a), .count(count_a), .overflow(ovf_a)
    );

    instr_queue_reg #(.DATA_W(12), .OP_W(4), .DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .data_in(din), .Ii(ii), .Inext(inext), .flush(flush), .Io(io),
        .opt(opt_b), .addt(addt_b), .op_code_o(opc_b), .address_o(adr_b), .ir_valid(irv_b),
        .full(full_b), .empty(empty_b), .count(count_b), .overflow(ovf_b)
    );

    // Model: an ordered list (index 0 = oldest) plus the IR word and flags
    int unsigned mq [2][8];
    int          mcnt [2];
    int unsigned mir [2];
    int          mirv [2];
    int          movf [2];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep(input int k, input int depth, input int dw);
        int unsigned d;
        int          c0;
        d  = din & ((1 << dw) - 1);
        c0 = mcnt[k];
        if (rst) begin
            mcnt[k] = 0; mir[k] = 0; mirv[k] = 0; movf[k] = 0;
        end else if (flush) begin
            mcnt[k] = 0; mirv[k] = 0; movf[k] = 0;
        end else begin
            if (inext) begin
                if (c0 > 0) begin
                    mir[k]  = mq[k][0];
                    mirv[k] = 1;
                    for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                    mcnt[k] = mcnt[k] - 1;
                end else if (ii) begin
                    mir[k]  = d;
                    mirv[k] = 1;
                end else begin
                    mirv[k] = 0;
                end
            end
            if (ii && !(inext && c0 == 0)) begin
                if (c0 == depth) movf[k] = 1;
                else begin
                    mq[k][mcnt[k]] = d;
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit i, input bit n, input bit f, input bit o,
                       input logic [11:0] d);
        @(negedge clk);
        #1;
        rst = r; ii = i; inext = n; flush = f; io = o; din = d;
        @(posedge clk);
        mstep(0, 4, 8);
        mstep(1, 8, 12);
        #1;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_opt",   32'(opt_a),   int'(mir[0] >> 4));
            chk("a_addt",  32'(addt_a),  int'(mir[0] & 15));
            chk("a_opc",   32'(opc_a),   (io && mirv[0] != 0) ? int'(mir[0] >> 4) : 0);
            chk("a_adr",   32'(adr_a),   (io && mirv[0] != 0) ? int'(mir[0] & 15) : 0);
            chk("a_irv",   32'(irv_a),   mirv[0]);
            chk("a_full",  32'(full_a),  int'(mcnt[0] == 4));
            chk("a_empty", 32'(empty_a), int'(mcnt[0] == 0));
            chk("a_count", 32'(count_a), mcnt[0]);
            chk("a_ovf",   32'(ovf_a),   movf[0]);
            chk("b_opt",   32'(opt_b),   int'(mir[1] >> 8));
            chk("b_addt",  32'(addt_b),  int'(mir[1] & 255));
            chk("b_opc",   32'(opc_b),   (io && mirv[1] != 0) ? int'(mir[1] >> 8) : 0);
            chk("b_adr",   32'(adr_b),   (io && mirv[1] != 0) ? int'(mir[1] & 255) : 0);
            chk("b_irv",   32'(irv_b),   mirv[1]);
            chk("b_full",  32'(full_b),  int'(mcnt[1] == 8));
            chk("b_empty", 32'(empty_b), int'(mcnt[1] == 0));
            chk("b_count", 32'(count_b), mcnt[1]);
            chk("b_ovf",   32'(ovf_b),   movf[1]);
        end
    end

    initial begin
        logic [7:0]  w [14];
        logic [7:0]  fw [4];
        logic [11:0] fill [5];
        bit          heavy;
        rst = 1'b1; ii = 1'b0; inext = 1'b0; flush = 1'b0; io = 1'b0; din = '0;
        chk_en = 1'b0;
        fill[0] = 12'h012; fill[1] = 12'h034; fill[2] = 12'h056; fill[3] = 12'h078; fill[4] = 12'h09A;
        fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33; fw[3] = 8'h44;
        for (int n = 0; n < 14; n++) w[n] = 8'(16 + n * 23);

        // Reset overrides every other input
        cyc(1, 1, 1, 1, 1, 12'h0A5);
        chk("rst_opt", 32'(opt_a), 0);
        chk("rst_addt", 32'(addt_a), 0);
        chk("rst_opc", 32'(opc_a), 0);
        chk("rst_adr", 32'(adr_a), 0);
        chk("rst_irv", 32'(irv_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk_en = 1'b1;

        // Fill to full, then one dropped push
        for (int j = 0; j < 4; j++) cyc(0, 1, 0, 0, 0, fill[j]);
        chk("fill_full", 32'(full_a), 1);
        chk("fill_count", 32'(count_a), 4);
        cyc(0, 1, 0, 0, 0, fill[4]);
        chk("fill_ovf", 32'(ovf_a), 1);
        chk("fill_count5", 32'(count_a), 4);

        // Drain in order with output enable asserted
        for (int j = 0; j < 4; j++) begin
            cyc(0, 0, 1, 0, 1, 12'h000);
            chk("drain_opc", 32'(opc_a), 2 * j + 1);
            chk("drain_adr", 32'(adr_a), 2 * j + 2);
        end
        cyc(0, 0, 1, 0, 1, 12'h000);
        chk("drain5_irv", 32'(irv_a), 0);
        chk("drain5_opc", 32'(opc_a), 0);
        chk("drain5_adr", 32'(adr_a), 0);
        chk("drain5_opt", 32'(opt_a), 7);
        chk("drain5_addt", 32'(addt_a), 8);

        // Bypass into the IR from empty
        cyc(1, 0, 0, 0, 0, 12'h000);
        cyc(0, 1, 1, 0, 0, 12'h0C3);
        chk("byp_opt", 32'(opt_a), 4'hC);
        chk("byp_addt", 32'(addt_a), 4'h3);
        chk("byp_irv", 32'(irv_a), 1);
        chk("byp_count", 32'(count_a), 0);
        chk("byp_bcount", 32'(count_b), 0);

        // Steady push+pop at depth 2 across several pointer wraps
        cyc(1, 0, 0, 0, 0, 12'h000);
        cyc(0, 1, 0, 0, 0, 12'(w[0]));
        cyc(0, 1, 0, 0, 0, 12'(w[1]));
        for (int j = 2; j < 14; j++) begin
            cyc(0, 1, 1, 0, 0, 12'(w[j]));
            chk("pp_count", 32'(count_a), 2);
            chk("pp_ir", 32'({opt_a, addt_a}), int'(w[j-2]));
        end

        // Flush with a concurrent push
        cyc(1, 0, 0, 0, 0, 12'h000);
        for (int j = 0; j < 4; j++) cyc(0, 1, 0, 0, 0, 12'(fw[j]));
        cyc(0, 1, 0, 0, 0, 12'h055);
        cyc(0, 0, 1, 0, 0, 12'h000);
        chk("fl_pre_count", 32'(count_a), 3);
        chk("fl_pre_ovf", 32'(ovf_a), 1);
        cyc(0, 1, 0, 1, 0, 12'h0FF);
        chk("fl_count", 32'(count_a), 0);
        chk("fl_irv", 32'(irv_a), 0);
        chk("fl_ovf", 32'(ovf_a), 0);
        chk("fl_opt", 32'(opt_a), 1);
        chk("fl_addt", 32'(addt_a), 1);
        cyc(0, 0, 1, 0, 1, 12'h000);
        chk("fl_after_irv", 32'(irv_a), 0);
        chk("fl_after_empty", 32'(empty_a), 1);

        // Output enable toggled mid-cycle, both widths
        cyc(1, 0, 0, 0, 0, 12'h000);
        cyc(0, 1, 1, 0, 0, 12'h0E7);
        io = 1'b1; #1;
        chk("io1_opc", 32'(opc_a), 4'hE);
        chk("io1_adr", 32'(adr_a), 4'h7);
        io = 1'b0; #1;
        chk("io0_opc", 32'(opc_a), 0);
        chk("io0_adr", 32'(adr_a), 0);
        chk("io0_opt", 32'(opt_a), 4'hE);
        cyc(0, 1, 1, 0, 0, 12'hE07);
        io = 1'b1; #1;
        chk("io1_opc_b", 32'(opc_b), 4'hE);
        chk("io1_adr_b", 32'(adr_b), 8'h07);
        io = 1'b0; #1;
        chk("io0_opc_b", 32'(opc_b), 0);
        chk("io0_adr_b", 32'(adr_b), 0);

        // Random traffic; alternate producer-heavy and balanced phases
        for (int c = 0; c < 3000; c++) begin
            heavy = ((c / 200) % 2) == 1;
            cyc($urandom_range(0, 99) == 0,
                heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
                heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1,
                12'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue_reg.md
# instr_queue_reg

Parametrised instruction register with an integrated prefetch queue. Instruction words are pushed into a DEPTH-entry FIFO ahead of use. On each advance request, the controller moves the oldest word into the current instruction register (IR). The IR is split into opcode and address fields, which are driven onto the internal bus only when output-enabled. The block sits between the memory/bus data path and the control sequencer, replacing the fixed 8-bit single-entry instruction register.

## Interface

Parameters:
- DATA_W, 8, instruction word width.
- OP_W, 4, opcode field width (upper bits of the word); address width ADDR_W = DATA_W-OP_W, must be ≥1.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  instruction word to push.
- Ii  in  1  push request for data_in.
- Inext  in  1  advance request: load the next instruction into the IR.
- flush  in  1  discard queued words and invalidate the IR (branch/jump).
- Io  in  1  output enable for the gated bus outputs.
- opt  out  OP_W  IR opcode field, registered, ungated.
- addt  out  ADDR_W  IR address field, registered, ungated.
- op_code_o  out  OP_W  opcode when Io && ir_valid, else 0.
- address_o  out  ADDR_W  address when Io && ir_valid, else 0.
- ir_valid  out  1  IR holds a live instruction.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  queued words, excluding the IR.
- overflow  out  1  sticky: a push was dropped while full.

## Operation

- Reset (rst=1 at an edge) forces the following, overriding all other inputs:
  - opt=0, addt=0, ir_valid=0.
  - count=0, read/write pointers=0.
  - overflow=0, full=0, empty=1.
- Priority per edge: rst > flush > push/advance.
- Flush:
  - count=0, pointers=0, ir_valid=0, overflow=0.
  - opt/addt hold their previous values.
  - Ii and Inext in the same cycle are ignored.
- Push, accepted when Ii && count<DEPTH (evaluated on pre-edge count):
  - data_in is written at the write pointer.
  - The write pointer wraps from DEPTH-1 to 0.
- Push while full (count==DEPTH):
  - The word is dropped and overflow is set to 1.
  - This applies even if Inext pops in the same cycle; there is no pass-through when full.
- Advance with count>0:
  - opt = head[DATA_W-1:ADDR_W], addt = head[ADDR_W-1:0].
  - ir_valid=1; the read pointer increments with wrap.
- Advance with count==0 and Ii=1 (bypass):
  - data_in loads directly into the IR and ir_valid=1.
  - The FIFO is untouched and count stays 0.
- Advance with count==0 and Ii=0:
  - ir_valid=0; opt/addt hold.
- Simultaneous accepted push and pop (count>0): count unchanged.
- count next value:
  - count+1 on accepted push only.
  - count−1 on pop only.
  - Unchanged otherwise (including bypass).
- Gated outputs are combinational from Io, ir_valid, opt, addt. Io has no effect on state.

## Timing

- Registered outputs (opt, addt, ir_valid, count, full, empty, overflow) update one edge after the qualifying inputs are sampled.
- Push-to-IR latency:
  - Minimum 1 edge via bypass when empty.
  - Otherwise, a word pushed at edge k can be advanced at edge k+1 at the earliest and appears in the IR after that edge.
- op_code_o/address_o follow Io within the same cycle (zero register delay).
- full/empty/count reflect post-edge state and are valid for the producer's next-cycle decision.
- rst asserted mid-stream clears everything at that edge; the first valid push is on the following edge.

## Test plan

- Reset:
  - Stimulus: rst=1 with Ii=Inext=flush=1, data_in=8'hA5.
  - Required: all outputs 0, empty=1, ir_valid=0.
- Fill/drain with defaults:
  - Push 8'h12, 8'h34, 8'h56, 8'h78, giving full=1, count=4.
  - Fifth push 8'h9A: dropped, overflow=1.
  - Four advances with Io=1: op_code_o/address_o = 1/2, 3/4, 5/6, 7/8.
  - Fifth advance: ir_valid=0, gated outputs 0, opt/addt still 7/8.
- Bypass:
  - Stimulus: empty, Ii=Inext=1, data_in=8'hC3.
  - Required: next cycle opt=4'hC, addt=4'h3, ir_valid=1, count=0.
- Simultaneous push/pop at count=2: count stays 2, order preserved across pointer wrap (run 10+ words through).
- Flush:
  - Stimulus: queue holding 3 words, IR valid, overflow=1; flush=1 with Ii=1.
  - Required: count=0, ir_valid=0, overflow=0, pushed word discarded, opt/addt unchanged.
- Output enable: with IR=8'hE7 valid, toggling Io gives op_code_o 4'hE↔0 and address_o 4'h7↔0 combinationally, with no state change; repeat with DATA_W=12, OP_W=4, DEPTH=8.
